regfile_sb: RTL and testbench
=============================

# regfile_sb

Parametrised architectural register file for the pipelined core's ID stage, successor to the fixed 2-read/1-write 64-bit file. Adds configurable width, depth and read-port count, a hardware zero-initialisation sweep after reset, and a per-register pending-write scoreboard that ID uses to detect RAW hazards on in-flight destinations. Reads are combinational with same-cycle write-back bypass. Register 0 is hardwired to zero.

## Interface
Parameters:
- DATA_WIDTH, 64, register width in bits
- ADDR_WIDTH, 5, register address width; DEPTH = 2**ADDR_WIDTH registers
- NUM_READ, 2, number of independent read ports (1..4)

Ports:
- clk  in  1  single clock, all state on rising edge
- reset  in  1  synchronous, active-high
- init_done  out  1  high once the zero sweep has completed; low in CLEAR
- rd_addr  in  NUM_READ*ADDR_WIDTH  packed read addresses, port k at bits [k*ADDR_WIDTH +: ADDR_WIDTH]
- rd_data  out  NUM_READ*DATA_WIDTH  packed read data, same packing
- rd_pending  out  NUM_READ  bit k high when port k's register has an outstanding write
- wr_en  in  1  write-back enable
- wr_addr  in  ADDR_WIDTH  write-back address
- wr_data  in  DATA_WIDTH  write-back data
- issue_en  in  1  mark a destination register as pending
- issue_addr  in  ADDR_WIDTH  destination address being issued

## Operation
- FSM, two states: CLEAR, RUN. Encoding is free.
- reset high at an edge: state <= CLEAR, clear_cnt <= 0, all pending bits <= 0. Storage contents are not touched in that cycle.
- CLEAR, reset low: each edge writes 0 to reg[clear_cnt] and increments clear_cnt. On the edge where clear_cnt == DEPTH-1, state <= RUN.
- In CLEAR:
  - wr_en and issue_en are ignored.
  - rd_data is all 0 and rd_pending is all 0.
  - init_done is 0.
- RUN, write: if wr_en and wr_addr != 0, reg[wr_addr] <= wr_data. Writes to address 0 are dropped.
- RUN, scoreboard, evaluated per edge:
  - issue_en and issue_addr != 0 sets pending[issue_addr].
  - wr_en clears pending[wr_addr].
  - If issue and write-back name the same address in the same cycle, issue wins and the bit stays 1, because a newer producer now exists.
  - pending[0] is constantly 0.
- RUN, read port k, combinational:
  - addr == 0: data 0, pending 0.
  - wr_en and wr_addr == addr: data = wr_data (bypass), pending 0.
  - Otherwise: data = reg[addr], pending = pending[addr].
- Reads never reflect same-cycle issue_en. A newly issued destination shows pending from the next cycle.
- Reset asserted mid-RUN or mid-CLEAR restarts the sweep from 0. Any write in that cycle is dropped.

## Timing
- Outputs after reset edge: init_done = 0, rd_data = 0, rd_pending = 0.
- Sweep takes exactly DEPTH edges with reset low. init_done rises after the DEPTH-th such edge; that is 32 edges for the default configuration.
- Read latency is 0 cycles (combinational from rd_addr, wr_*, and state).
- Write latency: data is visible via bypass in the same cycle and from storage after the next edge.
- Pending set by issue is visible one edge after issue. Pending cleared by write-back reads 0 in the write-back cycle (bypass) and from storage after the edge.
- All read ports are fully independent. Any number of ports may read the same address.

## Test plan
- Reset, then hold reset low: init_done is 0 for 32 edges and 1 after the 32nd. All reads during CLEAR return 0. After the sweep, every address reads 0.
- Write during CLEAR: wr_en=1, wr_addr=5, wr_data=0xAA at sweep cycle 2. After init_done, reg 5 reads 0.
- Bypass: wr_en=1, wr_addr=7, wr_data=0x1234 while rd_addr port0=7 and port1=7. Both ports return 0x1234 in the same cycle and rd_pending=0. Next cycle, with wr_en=0, both still read 0x1234.
- x0 behaviour: write 0xFFFF to addr 0, then issue addr 0. Reads of addr 0 return 0 with pending 0.
- Scoreboard: issue addr 3, then read addr 3 next cycle gives pending=1. Write-back addr 3 = 0x55 gives same-cycle pending=0 and data 0x55. Then do issue and write-back of addr 4 in the same cycle: pending[4]=1 on the next cycle.
- Reset mid-RUN: after writing reg 9 = 0x99 and issuing addr 9, pulse reset. Pending bits read 0, init_done drops to 0, and after a 32-edge sweep reg 9 reads 0.

Source files
------------

// File: rtl/regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : regfile_sb
// Brief    : Parametrised register file with post-reset zero sweep and a
//            per-register pending-write scoreboard for RAW hazard detection.
// Revision : 1.0
// ============================================================================
module regfile_sb #(
    parameter int DATA_WIDTH = 64,
    parameter int ADDR_WIDTH = 5,
    parameter int NUM_READ   = 2
) (
    input  logic                           clk,
    input  logic                           reset,
    output logic                           init_done,
    input  logic [NUM_READ*ADDR_WIDTH-1:0] rd_addr,
    output logic [NUM_READ*DATA_WIDTH-1:0] rd_data,
    output logic [NUM_READ-1:0]            rd_pending,
    input  logic                           wr_en,
    input  logic [ADDR_WIDTH-1:0]          wr_addr,
    input  logic [DATA_WIDTH-1:0]          wr_data,
    input  logic                           issue_en,
    input  logic [ADDR_WIDTH-1:0]          issue_addr
);

    localparam int                    c_DEPTH    = 2 ** ADDR_WIDTH;
    localparam logic [ADDR_WIDTH-1:0] c_LAST_IDX = '1;
    localparam logic [ADDR_WIDTH-1:0] c_ZERO_IDX = '0;

    typedef enum logic [0:0] {
        S_CLEAR = 1'b0,
        S_RUN   = 1'b1
    } state_t;

    state_t                  r_state_q,     r_state_d;
    logic [ADDR_WIDTH-1:0]   r_clear_cnt_q, r_clear_cnt_d;
    logic [c_DEPTH-1:0]      r_pending_q,   r_pending_d;
    logic [DATA_WIDTH-1:0]   r_mem_q [c_DEPTH];

    logic                    w_mem_we;
    logic [ADDR_WIDTH-1:0]   w_mem_waddr;
    logic [DATA_WIDTH-1:0]   w_mem_wdata;

    always_comb begin
        r_state_d     = r_state_q;
        r_clear_cnt_d = r_clear_cnt_q;
        r_pending_d   = r_pending_q;
        w_mem_we      = 1'b0;
        w_mem_waddr   = c_ZERO_IDX;
        w_mem_wdata   = '0;
        if (reset) begin
            r_state_d     = S_CLEAR;
            r_clear_cnt_d = c_ZERO_IDX;
            r_pending_d   = '0;
        end else if (r_state_q == S_CLEAR) begin
            w_mem_we      = 1'b1;
            w_mem_waddr   = r_clear_cnt_q;
            r_clear_cnt_d = r_clear_cnt_q + 1'b1;
            if (r_clear_cnt_q == c_LAST_IDX) begin
                r_state_d = S_RUN;
            end
        end else begin
            if (wr_en && (wr_addr != c_ZERO_IDX)) begin
                w_mem_we    = 1'b1;
                w_mem_waddr = wr_addr;
                w_mem_wdata = wr_data;
            end
            // Clear before set so a same-cycle issue to the same register wins.
            if (wr_en) begin
                r_pending_d[wr_addr] = 1'b0;
            end
            if (issue_en && (issue_addr != c_ZERO_IDX)) begin
                r_pending_d[issue_addr] = 1'b1;
            end
            r_pending_d[0] = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        r_state_q     <= r_state_d;
        r_clear_cnt_q <= r_clear_cnt_d;
        r_pending_q   <= r_pending_d;
    end

    always_ff @(posedge clk) begin
        if (w_mem_we) begin
            r_mem_q[w_mem_waddr] <= w_mem_wdata;
        end
    end

    assign init_done = (r_state_q == S_RUN);

    for (genvar k = 0; k < NUM_READ; k++) begin : g_read
        logic [ADDR_WIDTH-1:0] w_addr;
        logic [DATA_WIDTH-1:0] w_data;
        logic                  w_pend;

        assign w_addr = rd_addr[k*ADDR_WIDTH +: ADDR_WIDTH];

        always_comb begin
            w_data = '0;
            w_pend = 1'b0;
            if ((r_state_q == S_RUN) && (w_addr != c_ZERO_IDX)) begin
                if (wr_en && (wr_addr == w_addr)) begin
                    w_data = wr_data;
                end else begin
                    w_data = r_mem_q[w_addr];
                    w_pend = r_pending_q[w_addr];
                end
            end
        end

        assign rd_data[k*DATA_WIDTH +: DATA_WIDTH] = w_data;
        assign rd_pending[k]                       = w_pend;
    end : g_read

endmodule : regfile_sb
`default_nettype wire

// File: tb/tb_regfile_sb.sv
`default_nettype none
// ============================================================================
// Module   : tb_regfile_sb
// Brief    : Scoreboard bench for regfile_sb: directed scenarios then random
//            traffic checked against an array-based reference model.
// Revision : 1.0
// ============================================================================
module tb_regfile_sb;

    logic        clk = 1'b0;
    logic        reset;
    logic        init_done;
    logic [9:0]  rd_addr;
    logic [127:0] rd_data;
    logic [1:0]  rd_pending;
    logic        wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic        issue_en;
    logic [4:0]  issue_addr;

    regfile_sb #(
        .DATA_WIDTH(64),
        .ADDR_WIDTH(5),
        .NUM_READ  (2)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .init_done (init_done),
        .rd_addr   (rd_addr),
        .rd_data   (rd_data),
        .rd_pending(rd_pending),
        .wr_en     (wr_en),
        .wr_addr   (wr_addr),
        .wr_data   (wr_data),
        .issue_en  (issue_en),
        .issue_addr(issue_addr)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        init;
        logic [63:0] d0;
        logic [63:0] d1;
        logic        p0;
        logic        p1;
    } exp_t;

    exp_t q[$];
    int   checks   = 0;
    int   failures = 0;

    // Reference model: register contents, pending set, and sweep progress.
    logic [63:0] m_regs [32];
    bit          m_pend [32];
    bit          m_run   = 0;
    bit          m_known = 0;
    int          m_left  = 0;

    task automatic check1(input string name, input logic got, input logic want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%b want=%b at %0t", name, got, want, $time);
        end
    endtask

    task automatic check64(input string name, input logic [63:0] got, input logic [63:0] want);
        checks++;
        if (got !== want) begin
            failures++;
            $display("FAIL %s got=%h want=%h at %0t", name, got, want, $time);
        end
    endtask

    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (q.size() > 0) begin
                e = q.pop_front();
                check1 ("init_done",   init_done,       e.init);
                check64("rd_data0",    rd_data[63:0],   e.d0);
                check64("rd_data1",    rd_data[127:64], e.d1);
                check1 ("rd_pending0", rd_pending[0],   e.p0);
                check1 ("rd_pending1", rd_pending[1],   e.p1);
            end
        end
    end

    function automatic void expect_port(input logic [4:0] a, input logic we,
                                        input logic [4:0] wa, input logic [63:0] wd,
                                        output logic [63:0] d, output logic p);
        d = 64'd0;
        p = 1'b0;
        if (m_run && a != 5'd0) begin
            if (we && wa == a) begin
                d = wd;
            end else begin
                d = m_regs[a];
                p = m_pend[a];
            end
        end
    endfunction

    task automatic cycle(input logic r, input logic we, input logic [4:0] wa,
                         input logic [63:0] wd, input logic ie, input logic [4:0] ia,
                         input logic [4:0] a0, input logic [4:0] a1);
        exp_t e;
        reset      = r;
        wr_en      = we;
        wr_addr    = wa;
        wr_data    = wd;
        issue_en   = ie;
        issue_addr = ia;
        rd_addr    = {a1, a0};
        if (m_known) begin
            e.init = m_run;
            expect_port(a0, we, wa, wd, e.d0, e.p0);
            expect_port(a1, we, wa, wd, e.d1, e.p1);
            q.push_back(e);
        end
        @(posedge clk);
        if (r) begin
            m_known = 1;
            m_run   = 0;
            m_left  = 32;
            for (int i = 0; i < 32; i++) m_pend[i] = 0;
        end else if (m_known && !m_run) begin
            m_left--;
            if (m_left == 0) begin
                for (int i = 0; i < 32; i++) m_regs[i] = 64'd0;
                m_run = 1;
            end
        end else if (m_known) begin
            if (we && wa != 5'd0) m_regs[wa] = wd;
            if (we) m_pend[wa] = 0;
            if (ie && ia != 5'd0) m_pend[ia] = 1;
        end
        #1;
    endtask

    task automatic idle_read(input logic [4:0] a0, input logic [4:0] a1);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, a0, a1);
    endtask

    initial begin : stimulus
        logic [4:0] ra0, ra1, wa, ia;
        reset = 1'b1; wr_en = 1'b0; wr_addr = '0; wr_data = '0;
        issue_en = 1'b0; issue_addr = '0; rd_addr = '0;
        @(posedge clk);
        #1;

        // Reset, then sweep with a write attempt at sweep cycle 2.
        cycle(1'b1, 1'b0, 5'd0, 64'd0, 1'b0, 5'd0, 5'd1, 5'd2);
        for (int i = 0; i < 32; i++) begin
            if (i == 2) cycle(1'b0, 1'b1, 5'd5, 64'hAA, 1'b1, 5'd6, 5'd5, 5'd6);
            else        idle_read(5'(i), 5'(31 - i));
        end
        for (int i = 0; i < 16; i++) idle_read(5'(2 * i), 5'(2 * i + 1));

        // Same-cycle bypass on both ports, then from storage.
        cycle(1'b0, 1'b1, 5'd7, 64'h1234, 1'b0, 5'd0, 5'd7, 5'd7);
        idle_read(5'd7, 5'd7);

        // Register 0 ignores writes and issues.
        cycle(1'b0, 1'b1, 5'd0, 64'hFFFF, 1'b0, 5'd0, 5'd0, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd0, 5'd0, 5'd0);
        idle_read(5'd0, 5'd0);

        // Scoreboard set, clear-by-bypass, and issue-wins collision.
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd3, 5'd3, 5'd3);
        idle_read(5'd3, 5'd3);
        cycle(1'b0, 1'b1, 5'd3, 64'h55, 1'b0, 5'd0, 5'd3, 5'd4);
        cycle(1'b0, 1'b1, 5'd4, 64'h44, 1'b1, 5'd4, 5'd4, 5'd3);
        idle_read(5'd4, 5'd3);

        // Reset mid-run restarts the sweep and clears the scoreboard.
        cycle(1'b0, 1'b1, 5'd9, 64'h99, 1'b0, 5'd0, 5'd9, 5'd0);
        cycle(1'b0, 1'b0, 5'd0, 64'd0, 1'b1, 5'd9, 5'd9, 5'd9);
        idle_read(5'd9, 5'd9);
        cycle(1'b1, 1'b1, 5'd9, 64'h77, 1'b0, 5'd0, 5'd9, 5'd4);
        for (int i = 0; i < 33; i++) idle_read(5'd9, 5'd4);

        // Random traffic biased toward a few registers to force collisions.
        for (int n = 0; n < 3000; n++) begin
            ra0 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            ra1 = ($urandom_range(0, 3) == 0) ? 5'($urandom) : 5'($urandom_range(0, 6));
            wa  = 5'($urandom_range(0, 6));
            ia  = 5'($urandom_range(0, 6));
            cycle(($urandom_range(0, 399) == 0), ($urandom_range(0, 1) == 1), wa,
                  {$urandom, $urandom}, ($urandom_range(0, 2) == 0), ia, ra0, ra1);
        end

        repeat (2) @(negedge clk);
        checks++;
        if (q.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain got=%0d want=0", q.size());
        end
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule : tb_regfile_sb
`default_nettype wire
